// File: rtl/byte_stream_rr_arbiter.sv
// Round-robin arbiter that merges N_REQ valid/ready byte producers onto one
// registered output channel, granting bounded bursts and tagging each beat with its source.
module byte_stream_rr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int SRC_W     = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          valid_i,
    input  logic [N_REQ*DATA_W-1:0]   data_i,
    output logic [N_REQ-1:0]          ready_o,
    output logic                      valid_o,
    output logic [DATA_W-1:0]         data_o,
    output logic [SRC_W-1:0]          src_o,
    input  logic                      ready_i,
    output logic                      busy_o
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [SRC_W-1:0]  ptr_r;
    logic [SRC_W-1:0]  ptr_nxt_s;
    logic [SRC_W-1:0]  owner_r;
    logic [SRC_W-1:0]  owner_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              valid_r;
    logic [DATA_W-1:0] data_r;
    logic [SRC_W-1:0]  src_r;
    logic              busy_r;

    logic              out_free_s;
    logic              any_valid_s;
    logic              accept_s;
    logic              keep_s;
    logic [SRC_W-1:0]  base_s;
    logic [SRC_W-1:0]  sel_s;
    logic [DATA_W-1:0] sel_data_s;
    logic [N_REQ-1:0]  ready_s;

    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] idx);
        if (idx == SRC_W'(N_REQ - 1)) begin
            wrap_inc = '0;
        end else begin
            wrap_inc = idx + SRC_W'(1);
        end
    endfunction

    // First requesting index at or after base, wrapping N_REQ-1 -> 0.
    function automatic logic [SRC_W-1:0] rr_pick(input logic [SRC_W-1:0] base,
                                                 input logic [N_REQ-1:0] req);
        logic [SRC_W-1:0] idx;
        logic             found;
        rr_pick = base;
        found   = 1'b0;
        idx     = base;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end else begin
                found   = found;
            end
            idx = wrap_inc(idx);
        end
    endfunction

    // Grant selection: hold the owner while its burst lasts, otherwise scan from the next slot.
    always_comb begin
        out_free_s  = ~valid_r | ready_i;
        any_valid_s = |valid_i;
        keep_s      = 1'b0;
        base_s      = ptr_r;
        if (state_r == BURST) begin
            if (valid_i[owner_r] && (cnt_r < CNT_W'(MAX_BURST))) begin
                keep_s = 1'b1;
                base_s = owner_r;
            end else begin
                keep_s = 1'b0;
                base_s = wrap_inc(owner_r);
            end
        end else begin
            keep_s = 1'b0;
            base_s = ptr_r;
        end
        sel_s    = rr_pick(base_s, valid_i);
        accept_s = rst_n & out_free_s & any_valid_s;
    end

    // One-hot ready and data mux for the selected requester.
    always_comb begin
        ready_s    = '0;
        sel_data_s = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (SRC_W'(k) == sel_s) begin
                ready_s[k] = accept_s;
                sel_data_s = data_i[k*DATA_W +: DATA_W];
            end else begin
                ready_s[k] = 1'b0;
            end
        end
    end

    assign ready_o = ready_s;

    // Burst bookkeeping: a stalled output leaves everything untouched so the owner keeps priority.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        owner_nxt_s = owner_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (MAX_BURST == 1) begin
                        ptr_nxt_s = wrap_inc(sel_s);
                    end else begin
                        state_nxt_s = BURST;
                        owner_nxt_s = sel_s;
                        cnt_nxt_s   = CNT_W'(1);
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BURST: begin
                if (!out_free_s) begin
                    state_nxt_s = BURST;
                end else if (accept_s) begin
                    if (keep_s) begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end else begin
                        ptr_nxt_s   = wrap_inc(owner_r);
                        owner_nxt_s = sel_s;
                        cnt_nxt_s   = CNT_W'(1);
                    end
                end else begin
                    state_nxt_s = IDLE;
                    ptr_nxt_s   = wrap_inc(owner_r);
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ptr_r   <= '0;
            owner_r <= '0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            owner_r <= owner_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= (state_nxt_s == BURST);
        end
    end

    // Output beat register; valid drops only when the held beat leaves with nothing replacing it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= '0;
            src_r   <= '0;
        end else if (accept_s) begin
            valid_r <= 1'b1;
            data_r  <= sel_data_s;
            src_r   <= sel_s;
        end else if (ready_i) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign valid_o = valid_r;
    assign data_o  = data_r;
    assign src_o   = src_r;
    assign busy_o  = busy_r;

endmodule

// File: tb/tb_byte_stream_rr_arbiter.sv
// Self-checking bench for byte_stream_rr_arbiter: vector table, directed corner
// sequences and a randomized run against a behavioural arbitration model.
module tb_byte_stream_rr_arbiter;

    localparam int N_REQ     = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;
    localparam int SRC_W     = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N_REQ-1:0]        valid_i;
    logic [N_REQ*DATA_W-1:0] data_i;
    logic [N_REQ-1:0]        ready_o;
    logic                    valid_o;
    logic [DATA_W-1:0]       data_o;
    logic [SRC_W-1:0]        src_o;
    logic                    ready_i;
    logic                    busy_o;

    int checks   = 0;
    int failures = 0;

    byte_stream_rr_arbiter #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i),
        .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o), .src_o(src_o),
        .ready_i(ready_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst_n;
        logic [N_REQ-1:0] valid;
        logic             rdy;
        logic [N_REQ-1:0] exp_ready;
        logic             exp_vo;
        logic [7:0]       exp_do;
        logic [1:0]       exp_so;
        logic             exp_busy;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        valid_i = '0;
        ready_i = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_lane(input int k, input logic [7:0] v);
        data_i[k*DATA_W +: DATA_W] = v;
    endtask

    // Behavioural model: who owns the channel, how many beats it used, where the scan resumes.
    int         m_ptr, m_owner, m_cnt, m_so;
    bit         m_burst, m_vo;
    logic [7:0] m_do;

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_so = 0;
        m_burst = 1'b0; m_vo = 1'b0; m_do = 8'h00;
    endtask

    function automatic int m_winner(input logic [N_REQ-1:0] v, output bit keep);
        int base;
        keep = m_burst && v[m_owner] && (m_cnt < MAX_BURST);
        if (keep) return m_owner;
        base = m_burst ? (m_owner + 1) % N_REQ : m_ptr;
        for (int j = 0; j < N_REQ; j++) begin
            if (v[(base + j) % N_REQ]) return (base + j) % N_REQ;
        end
        return -1;
    endfunction

    function automatic logic [N_REQ-1:0] m_ready(input logic r, input logic [N_REQ-1:0] v,
                                                 input logic rdy);
        bit keep;
        int w;
        w = m_winner(v, keep);
        if (r && (!m_vo || rdy) && w >= 0) return 4'b0001 << w;
        return 4'b0000;
    endfunction

    task automatic model_clock(input logic r, input logic [N_REQ-1:0] v,
                               input logic [31:0] d, input logic rdy);
        bit keep, free, acc;
        int w;
        if (!r) begin
            model_reset();
        end else begin
            w    = m_winner(v, keep);
            free = !m_vo || rdy;
            acc  = free && (w >= 0);
            if (acc) begin
                m_do = d[w*DATA_W +: DATA_W];
                m_so = w;
                m_vo = 1'b1;
            end else if (rdy) begin
                m_vo = 1'b0;
            end
            if (free && acc) begin
                if (keep) begin
                    m_cnt++;
                end else begin
                    if (m_burst) m_ptr = (m_owner + 1) % N_REQ;
                    m_owner = w;
                    m_cnt   = 1;
                    m_burst = 1'b1;
                end
            end else if (free && m_burst) begin
                m_burst = 1'b0;
                m_ptr   = (m_owner + 1) % N_REQ;
            end
        end
    endtask

    initial begin
        logic [N_REQ-1:0] exp_rdy;
        logic [N_REQ-1:0] acc;

        vecs[0]  = '{1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
        vecs[1]  = '{1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
        vecs[2]  = '{1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
        vecs[3]  = '{1'b1, 4'hF, 1'b1, 4'h1, 1'b1, 8'h09, 2'd0, 1'b1};
        vecs[4]  = '{1'b1, 4'hF, 1'b1, 4'h1, 1'b1, 8'h09, 2'd0, 1'b1};
        vecs[5]  = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 8'h09, 2'd0, 1'b1};
        vecs[6]  = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 8'h09, 2'd0, 1'b1};
        vecs[7]  = '{1'b1, 4'hF, 1'b1, 4'h1, 1'b1, 8'h09, 2'd0, 1'b1};
        vecs[8]  = '{1'b1, 4'hF, 1'b1, 4'h1, 1'b1, 8'h09, 2'd0, 1'b1};
        vecs[9]  = '{1'b1, 4'hF, 1'b1, 4'h2, 1'b1, 8'h1A, 2'd1, 1'b1};
        vecs[10] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 8'h1A, 2'd1, 1'b0};
        vecs[11] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 8'h1A, 2'd1, 1'b0};
        vecs[12] = '{1'b1, 4'h9, 1'b1, 4'h8, 1'b1, 8'h3C, 2'd3, 1'b1};
        vecs[13] = '{1'b1, 4'h1, 1'b1, 4'h1, 1'b1, 8'h09, 2'd0, 1'b1};
        vecs[14] = '{1'b0, 4'hF, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
        vecs[15] = '{1'b1, 4'h4, 1'b0, 4'h4, 1'b1, 8'h2B, 2'd2, 1'b1};

        rst_n   = 1'b0;
        valid_i = 4'hF;
        ready_i = 1'b1;
        data_i  = 32'h3C2B1A09;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            rst_n   = vecs[i].rst_n;
            valid_i = vecs[i].valid;
            ready_i = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), 32'(ready_o), 32'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid_o", i), 32'(valid_o), 32'(vecs[i].exp_vo));
            chk($sformatf("vec%0d_data_o", i), 32'(data_o), 32'(vecs[i].exp_do));
            chk($sformatf("vec%0d_src_o", i), 32'(src_o), 32'(vecs[i].exp_so));
            chk($sformatf("vec%0d_busy_o", i), 32'(busy_o), 32'(vecs[i].exp_busy));
        end

        // Fairness: all requesters valid, bursts of MAX_BURST in order, no gaps.
        do_reset();
        data_i  = 32'h3C2B1A09;
        valid_i = 4'hF;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("fair_src", 32'(src_o), 32'((i / 4) % 4));
            chk("fair_valid", 32'(valid_o), 32'd1);
        end

        // Early release: req2 drops after two beats, req3 follows without a bubble.
        do_reset();
        valid_i = 4'b0100;
        set_lane(2, 8'hA1);
        step();
        chk("early_d1", 32'(data_o), 32'hA1);
        chk("early_s1", 32'(src_o), 32'd2);
        set_lane(2, 8'hA2);
        step();
        chk("early_d2", 32'(data_o), 32'hA2);
        valid_i = 4'b1000;
        set_lane(3, 8'hB3);
        @(negedge clk);
        chk("early_ready3", 32'(ready_o), 32'h8);
        @(posedge clk);
        #1;
        chk("early_d3", 32'(data_o), 32'hB3);
        chk("early_s3", 32'(src_o), 32'd3);
        chk("early_v3", 32'(valid_o), 32'd1);

        // Backpressure mid-burst: outputs frozen, burst count not advanced by the stall.
        do_reset();
        valid_i = 4'b0110;
        set_lane(1, 8'h60);
        set_lane(2, 8'h70);
        step();
        chk("bp_d60", 32'(data_o), 32'h60);
        set_lane(1, 8'h61);
        step();
        ready_i = 1'b0;
        set_lane(1, 8'h62);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_stall_ready", 32'(ready_o), 32'h0);
            @(posedge clk);
            #1;
            chk("bp_stall_data", 32'(data_o), 32'h61);
            chk("bp_stall_src", 32'(src_o), 32'd1);
            chk("bp_stall_valid", 32'(valid_o), 32'd1);
        end
        ready_i = 1'b1;
        step();
        chk("bp_d62", 32'(data_o), 32'h62);
        set_lane(1, 8'h63);
        step();
        chk("bp_d63", 32'(data_o), 32'h63);
        chk("bp_s63", 32'(src_o), 32'd1);
        set_lane(1, 8'h64);
        step();
        chk("bp_switch_data", 32'(data_o), 32'h70);
        chk("bp_switch_src", 32'(src_o), 32'd2);

        // Wrap: leave ptr at 3, then only req3 and req0 compete.
        do_reset();
        data_i  = 32'h3C2B1A09;
        valid_i = 4'b0100;
        step();
        valid_i = 4'b0000;
        step();
        step();
        chk("wrap_drained", 32'(valid_o), 32'd0);
        valid_i = 4'b1001;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("wrap_src", 32'(src_o), ((i / 4) % 2 == 0) ? 32'd3 : 32'd0);
        end

        // Reset mid-burst drops the held beat; arbitration restarts at req0.
        do_reset();
        valid_i = 4'b0010;
        step();
        step();
        chk("rmb_valid", 32'(valid_o), 32'd1);
        chk("rmb_src", 32'(src_o), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rmb_ready_in_reset", 32'(ready_o), 32'h0);
        @(posedge clk);
        #1;
        chk("rmb_valid_dropped", 32'(valid_o), 32'd0);
        chk("rmb_busy_dropped", 32'(busy_o), 32'd0);
        rst_n   = 1'b1;
        valid_i = 4'hF;
        @(negedge clk);
        chk("rmb_ready_req0", 32'(ready_o), 32'h1);
        @(posedge clk);
        #1;
        chk("rmb_src_req0", 32'(src_o), 32'd0);

        // Randomized traffic against the behavioural model; producers hold beats until accepted.
        do_reset();
        model_reset();
        valid_i = '0;
        for (int c = 0; c < 800; c++) begin
            rst_n   = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
            ready_i = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            exp_rdy = m_ready(rst_n, valid_i, ready_i);
            @(negedge clk);
            chk("rand_ready", 32'(ready_o), 32'(exp_rdy));
            acc = exp_rdy & valid_i;
            model_clock(rst_n, valid_i, data_i, ready_i);
            @(posedge clk);
            #1;
            chk("rand_valid_o", 32'(valid_o), 32'(m_vo));
            chk("rand_busy_o", 32'(busy_o), 32'(m_burst));
            if (m_vo) begin
                chk("rand_data_o", 32'(data_o), 32'(m_do));
                chk("rand_src_o", 32'(src_o), 32'(m_so));
            end
            for (int k = 0; k < N_REQ; k++) begin
                if (acc[k] || !valid_i[k]) begin
                    valid_i[k] = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
                    set_lane(k, 8'($urandom_range(0, 255)));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
